sequenciador_atuadores: RTL and testbench
=========================================

// Module: sequenciador_atuadores
// PURPOSE
//  Parametrised sequencer for NCH brew actuators (pump, boiler, valve, ...), driven one at a time in channel order.
//  Per-channel on-time comes from a packed table indexed by the 2-bit modo from the serial receiver.
//  Channels flagged in EARLY_MASK end early on a feedback input (e.g. temperature reached); for them the table time is a timeout.
//  Replaces the separate pump/boiler/valve controllers and their wait counters in the datapath.
// PARAMETERS
//  NCH        3             number of actuator channels (1..8)
//  CW         2             channel index width, >= clog2(NCH)
//  BASE_TICKS 50000000      clocks per time unit (1 s at 50 MHz)
//  GAP_TICKS  50000000      clocks with all actuators off between channels
//  DUR_S      96'h0A080604_1E1E1E1E_0F0C0906   8-bit units per (channel c, modo m) at bits [(c*4+m)*8 +: 8]
//  EARLY_MASK 3'b010        bit c=1: channel c ends on done_in[c]; expiry = timeout
// PORTS
//  clock        in   1     system clock
//  reset        in   1     synchronous, active-high
//  start        in   1     begin sequence; sampled only in IDLE or ERROR
//  abort        in   1     stop immediately, return to IDLE
//  modo         in   2     recipe select, latched on accepted start
//  done_in      in   NCH   per-channel completion feedback
//  atuador      out  NCH   actuator drives, one-hot or zero, registered
//  ocupado      out  1     high in SELECT/ACTIVE/GAP
//  canal        out  CW    current channel index
//  pronto       out  1     one-cycle pulse on successful completion
//  timeout      out  1     high while in ERROR
//  falha_canal  out  CW    channel that timed out; valid while timeout=1
// BEHAVIOUR
//  Reset: state IDLE; atuador=0, ocupado=0, canal=0, pronto=0, timeout=0, falha_canal=0, all counters 0.
//  Priority: reset > abort > everything else.
//  abort in any non-IDLE state: next cycle IDLE, atuador=0, no pronto, timeout cleared. abort+start together in IDLE: stays IDLE.
//  IDLE: start=1 -> latch modo_r, canal=0, SELECT.
//  SELECT (1 cycle): d=DUR_S[canal,modo_r]. d=0 -> channel skipped (atuador never asserted), go to next-channel step. Else load timers -> ACTIVE.
//  ACTIVE: atuador[canal]=1. Prescaler 0..BASE_TICKS-1; unit counter increments on wrap.
//   - Normal end: atuador high exactly d*BASE_TICKS cycles.
//   - EARLY_MASK[canal] and done_in[canal]=1 in cycle k -> atuador low at k+1, go to next-channel step.
//   - EARLY_MASK[canal] and d*BASE_TICKS cycles pass with no done_in -> ERROR, falha_canal=canal.
//   - done_in on the last counted cycle = success (done beats expiry).
//   - done_in of non-early or non-current channels is ignored.
//  Next-channel step: canal=NCH-1 -> DONE; else GAP.
//  GAP: atuador=0 for exactly GAP_TICKS cycles; then canal+1 -> SELECT. GAP_TICKS=0 -> straight to SELECT.
//  DONE: pronto=1 for one cycle -> IDLE. canal holds its last value until the next start.
//  ERROR: atuador=0, timeout=1; held until start (clear timeout, restart from channel 0) or abort/reset (-> IDLE).
//  start while ocupado=1: ignored. modo changes after start: ignored until the next start.
//  Latency: start sampled at cycle t -> SELECT at t+1 -> atuador[0]=1 from t+2 (if d0 != 0).
//  Counter widths cover max(BASE_TICKS, GAP_TICKS) and 8-bit units; no wrap beyond 255 units.
// TESTING (NCH=3, BASE_TICKS=4, GAP_TICKS=2, EARLY_MASK=3'b010, modo=1: d={3,2,1} for ch2..ch0)
//  Nominal, done_in[1] at its 5th active cycle: atuador = 001 x4, 000 x2, 010 x5, 000 x2, 100 x12; then one pronto pulse.
//  done_in[1] held low: 010 for exactly 8 cycles -> timeout=1, falha_canal=1, atuador=0 until start.
//  Mode with d0=0: ch0 skipped; atuador[1] high 3 cycles after start; atuador[0] never asserted.
//  abort mid-ACTIVE on ch2: atuador=0 next cycle, ocupado=0, no pronto; a fresh start runs a full sequence.
//  start pulses and modo toggles during ACTIVE: no effect on sequence timing; reset mid-GAP returns all outputs to reset values next cycle.
//  done_in[0] and done_in[2] held high throughout: ch0 and ch2 still run their full table times.

Source files
------------

// File: rtl/sequenciador_atuadores_if.sv
// Control/status bundle between the brew sequencer and whoever commands it.
// master: drives start/abort/modo/done_in and observes the actuator outputs.
// slave : the sequencer itself.
interface sequenciador_atuadores_if #(
  parameter int NCH = 3,
  parameter int CW  = 2
);
  logic           start;
  logic           abort;
  logic [1:0]     modo;
  logic [NCH-1:0] done_in;
  logic [NCH-1:0] atuador;
  logic           ocupado;
  logic [CW-1:0]  canal;
  logic           pronto;
  logic           timeout;
  logic [CW-1:0]  falha_canal;

  modport master (
    output start, abort, modo, done_in,
    input  atuador, ocupado, canal, pronto, timeout, falha_canal
  );

  modport slave (
    input  start, abort, modo, done_in,
    output atuador, ocupado, canal, pronto, timeout, falha_canal
  );
endinterface

// File: rtl/sequenciador_atuadores.sv
// Sequencer that drives NCH brew actuators one at a time, in channel order.
// Latency: start sampled at t -> SELECT at t+1 -> first actuator on from t+2.
// Backpressure: none; start is ignored while busy, abort always wins.
//
// Ports:
//   clock_i  system clock
//   reset_i  synchronous, active-high reset
//   seq_io   slave side of the control bundle:
//              start/abort/modo/done_in in; atuador (registered, one-hot or zero),
//              ocupado, canal, pronto (1-cycle), timeout, falha_canal out.
//
// Per-channel on-time comes from DUR_S, 8-bit units of BASE_TICKS clocks at
// bits [(c*4+m)*8 +: 8]. Channels in EARLY_MASK stop on done_in[c] and treat
// the table time as a timeout. All-off time between two actuations is
// GAP_TICKS clocks (the SELECT cycle counts as part of it); a channel with a
// zero duration is skipped without any gap.
module sequenciador_atuadores #(
  parameter int                NCH        = 3,
  parameter int                CW         = 2,
  parameter int                BASE_TICKS = 50000000,
  parameter int                GAP_TICKS  = 50000000,
  parameter logic [NCH*32-1:0] DUR_S      = 96'h0A080604_1E1E1E1E_0F0C0906,
  parameter logic [NCH-1:0]    EARLY_MASK = 3'b010
) (
  input logic                     clock_i,
  input logic                     reset_i,
  sequenciador_atuadores_if.slave seq_io
);

  localparam int MAXT = (BASE_TICKS > GAP_TICKS) ? BASE_TICKS : GAP_TICKS;
  localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam int NE   = 1 << (CW + 2);

  localparam logic [TW-1:0] PRESC_LAST = TW'(BASE_TICKS - 1);
  // GAP state covers GAP_TICKS-1 cycles; the following SELECT is the last off cycle.
  localparam logic [TW-1:0] GAP_LAST   = (GAP_TICKS >= 2) ? TW'(GAP_TICKS - 2) : '0;
  localparam logic [CW-1:0] LAST_CH    = CW'(NCH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ACTIVE,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  canal_q, canal_d;
  logic [1:0]     modo_q, modo_d;
  logic [TW-1:0]  presc_q, presc_d;
  logic [7:0]     units_q, units_d;
  logic [7:0]     dur_q, dur_d;
  logic [NCH-1:0] atuador_q, atuador_d;
  logic [CW-1:0]  falha_q, falha_d;

  // Duration table flattened into an array indexed by {canal, modo}; the
  // power-of-two size keeps out-of-range channel indices reading as zero.
  logic [7:0] dur_tab [NE];

  for (genvar e = 0; e < NE; e++) begin : g_dur
    if (e < NCH * 4) begin : g_used
      assign dur_tab[e] = DUR_S[e*8 +: 8];
    end else begin : g_unused
      assign dur_tab[e] = 8'd0;
    end
  end

  logic [7:0]     dur_sel;
  logic [NCH-1:0] onehot;
  logic           early_cur;
  logic           done_cur;

  always_comb begin
    dur_sel   = dur_tab[{canal_q, modo_q}];
    onehot    = '0;
    early_cur = 1'b0;
    done_cur  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (canal_q == CW'(i)) begin
        onehot[i] = 1'b1;
        early_cur = EARLY_MASK[i];
        // Feedback only matters for the current channel and only if it is early-ending.
        done_cur  = EARLY_MASK[i] & seq_io.done_in[i];
      end
    end
  end

  logic last_tick;
  logic adv;

  assign last_tick = (presc_q == PRESC_LAST) && (units_q == dur_q - 8'd1);

  always_comb begin
    state_d   = state_q;
    canal_d   = canal_q;
    modo_d    = modo_q;
    presc_d   = presc_q;
    units_d   = units_q;
    dur_d     = dur_q;
    atuador_d = '0;
    falha_d   = falha_q;
    adv       = 1'b0;

    if (seq_io.abort) begin
      // Abort from anywhere: everything off, back to IDLE (also covers abort+start in IDLE).
      state_d = S_IDLE;
      presc_d = '0;
      units_d = '0;
      falha_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (seq_io.start) begin
            modo_d  = seq_io.modo;
            canal_d = '0;
            state_d = S_SELECT;
          end
        end

        S_SELECT: begin
          if (dur_sel == 8'd0) begin
            // Skipped channel: nothing was switched, so no settling gap.
            if (canal_q == LAST_CH) begin
              state_d = S_DONE;
            end else begin
              canal_d = canal_q + CW'(1);
            end
          end else begin
            dur_d     = dur_sel;
            presc_d   = '0;
            units_d   = '0;
            atuador_d = onehot;
            state_d   = S_ACTIVE;
          end
        end

        S_ACTIVE: begin
          atuador_d = onehot;
          if (done_cur) begin
            // Checked before expiry so feedback on the final cycle still counts as success.
            atuador_d = '0;
            adv       = 1'b1;
          end else if (last_tick) begin
            atuador_d = '0;
            if (early_cur) begin
              falha_d = canal_q;
              state_d = S_ERROR;
            end else begin
              adv = 1'b1;
            end
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            units_d = units_q + 8'd1;
          end else begin
            presc_d = presc_q + TW'(1);
          end
        end

        S_GAP: begin
          if (presc_q == GAP_LAST) begin
            canal_d = canal_q + CW'(1);
            state_d = S_SELECT;
          end else begin
            presc_d = presc_q + TW'(1);
          end
        end

        S_DONE: begin
          state_d = S_IDLE;
        end

        S_ERROR: begin
          if (seq_io.start) begin
            modo_d  = seq_io.modo;
            canal_d = '0;
            state_d = S_SELECT;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase

      // Leaving a channel normally: finish, or pause before the next one.
      if (adv) begin
        if (canal_q == LAST_CH) begin
          state_d = S_DONE;
        end else if (GAP_TICKS <= 1) begin
          canal_d = canal_q + CW'(1);
          state_d = S_SELECT;
        end else begin
          presc_d = '0;
          state_d = S_GAP;
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      canal_q   <= '0;
      modo_q    <= '0;
      presc_q   <= '0;
      units_q   <= '0;
      dur_q     <= '0;
      atuador_q <= '0;
      falha_q   <= '0;
    end else begin
      state_q   <= state_d;
      canal_q   <= canal_d;
      modo_q    <= modo_d;
      presc_q   <= presc_d;
      units_q   <= units_d;
      dur_q     <= dur_d;
      atuador_q <= atuador_d;
      falha_q   <= falha_d;
    end
  end

  assign seq_io.atuador     = atuador_q;
  assign seq_io.ocupado     = (state_q == S_SELECT) || (state_q == S_ACTIVE) || (state_q == S_GAP);
  assign seq_io.canal       = canal_q;
  assign seq_io.pronto      = (state_q == S_DONE);
  assign seq_io.timeout     = (state_q == S_ERROR);
  assign seq_io.falha_canal = falha_q;

endmodule

// File: tb/tb_sequenciador_atuadores.sv
// Bench for sequenciador_atuadores with NCH=3, BASE_TICKS=4, GAP_TICKS=2,
// EARLY_MASK=3'b010. Expected per-cycle outputs are built from the duration
// table as an actuation timeline (on for d*4 cycles, off between channels).
module tb_sequenciador_atuadores;

  localparam int NCH = 3;
  localparam int CW  = 2;
  localparam int B   = 4;
  localparam int G   = 2;
  localparam logic [2:0] EMASK = 3'b010;

  // Units per [channel][modo], written as a plain table.
  // modo0: 2,1,1  modo1: 1,2,3  modo2: 0,2,1  modo3: 1,1,0  (ch0,ch1,ch2)
  int dur [NCH][4] = '{'{2, 1, 0, 1}, '{1, 2, 2, 1}, '{1, 3, 1, 0}};

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  sequenciador_atuadores_if #(.NCH(NCH), .CW(CW)) seq_if ();

  sequenciador_atuadores #(
    .NCH        (NCH),
    .CW         (CW),
    .BASE_TICKS (B),
    .GAP_TICKS  (G),
    .DUR_S      (96'h00010301_01020201_01000102),
    .EARLY_MASK (EMASK)
  ) dut (
    .clock_i (clock),
    .reset_i (reset),
    .seq_io  (seq_if)
  );

  typedef struct {
    logic [2:0] atu;
    bit         ocu;
    bit         pr;
    bit         to;
    int         canal;
    logic [2:0] done;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [2:0] a, input bit o, input bit p, input bit t,
                              input int c, input logic [2:0] d);
    ent_t r;
    r.atu = a; r.ocu = o; r.pr = p; r.to = t; r.canal = c; r.done = d;
    return r;
  endfunction

  // Timeline after start is sampled: one off cycle to pick the channel, then
  // d*B on cycles (or e cycles if done arrives at on-cycle e of an early
  // channel), G off cycles between actuations, then pronto. Zero-duration
  // channels cost one off cycle and no gap. An early channel reaching its
  // full time without done ends in a held timeout.
  task automatic build(input int m, input int e, output bit err);
    logic [2:0] oh;
    int n;
    q.delete();
    err = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      oh = '0;
      oh[c] = 1'b1;
      q.push_back(mk(3'b000, 1'b1, 1'b0, 1'b0, c, 3'b000));
      if (dur[c][m] == 0) continue;
      n = dur[c][m] * B;
      if (EMASK[c] && e >= 1 && e <= n) begin
        for (int j = 1; j <= e; j++)
          q.push_back(mk(oh, 1'b1, 1'b0, 1'b0, c, (j == e) ? oh : 3'b000));
      end else begin
        for (int j = 1; j <= n; j++)
          q.push_back(mk(oh, 1'b1, 1'b0, 1'b0, c, 3'b000));
        if (EMASK[c]) begin
          for (int k = 0; k < 4; k++)
            q.push_back(mk(3'b000, 1'b0, 1'b0, 1'b1, c, 3'b000));
          err = 1'b1;
          return;
        end
      end
      if (c < NCH - 1)
        for (int g = 1; g < G; g++)
          q.push_back(mk(3'b000, 1'b1, 1'b0, 1'b0, c, 3'b000));
    end
    q.push_back(mk(3'b000, 1'b0, 1'b1, 1'b0, NCH - 1, 3'b000));
    q.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, NCH - 1, 3'b000));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".atuador"}, 32'(seq_if.atuador), 0);
    chk({tag, ".ocupado"}, 32'(seq_if.ocupado), 0);
    chk({tag, ".canal"}, 32'(seq_if.canal), 0);
    chk({tag, ".pronto"}, 32'(seq_if.pronto), 0);
    chk({tag, ".timeout"}, 32'(seq_if.timeout), 0);
    chk({tag, ".falha"}, 32'(seq_if.falha_canal), 0);
  endtask

  // Called at a negedge. cut: 0 none, 1 abort mid-ACTIVE of ch2, 2 reset mid-GAP.
  task automatic run_seq(input string name, input int m, input int e, input bit perturb,
                         input bit hold02, input int cut, output bit err);
    int cut_at;
    build(m, e, err);
    cut_at = -1;
    for (int i = 1; i < q.size(); i++) begin
      if (cut_at < 0 && cut == 1 && q[i].atu == 3'b100) cut_at = i + 3;
      if (cut_at < 0 && cut == 2 && q[i].ocu && q[i].atu == 3'b000 && q[i-1].atu != 3'b000)
        cut_at = i;
    end
    if (cut != 0 && cut_at < 0) chk({name, ".cut_point_found"}, 0, 1);
    seq_if.start = 1'b1;
    seq_if.modo  = 2'(m);
    @(negedge clock);
    seq_if.start = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      chk($sformatf("%s.atuador[%0d]", name, i), 32'(seq_if.atuador), 32'(q[i].atu));
      chk($sformatf("%s.ocupado[%0d]", name, i), 32'(seq_if.ocupado), 32'(q[i].ocu));
      chk($sformatf("%s.pronto[%0d]", name, i), 32'(seq_if.pronto), 32'(q[i].pr));
      chk($sformatf("%s.timeout[%0d]", name, i), 32'(seq_if.timeout), 32'(q[i].to));
      if (!q[i].to)
        chk($sformatf("%s.canal[%0d]", name, i), 32'(seq_if.canal), 32'(q[i].canal));
      else
        chk($sformatf("%s.falha[%0d]", name, i), 32'(seq_if.falha_canal), 32'(q[i].canal));
      if (i == cut_at) begin
        seq_if.done_in = '0;
        if (cut == 1) begin
          seq_if.abort = 1'b1;
          @(negedge clock);
          seq_if.abort = 1'b0;
          chk({name, ".abort.atuador"}, 32'(seq_if.atuador), 0);
          chk({name, ".abort.ocupado"}, 32'(seq_if.ocupado), 0);
          chk({name, ".abort.pronto"}, 32'(seq_if.pronto), 0);
          @(negedge clock);
          chk({name, ".abort.pronto_after"}, 32'(seq_if.pronto), 0);
          chk({name, ".abort.ocupado_after"}, 32'(seq_if.ocupado), 0);
        end else begin
          reset = 1'b1;
          @(negedge clock);
          reset = 1'b0;
          check_reset_vals({name, ".reset"});
        end
        err = 1'b0;
        return;
      end
      seq_if.done_in = q[i].done | (hold02 ? 3'b101 : (3'($urandom) & 3'b101));
      if (perturb && q[i].ocu) begin
        seq_if.start = 1'($urandom);
        seq_if.modo  = 2'($urandom);
      end else begin
        seq_if.start = 1'b0;
      end
      @(negedge clock);
    end
    seq_if.start   = 1'b0;
    seq_if.done_in = '0;
  endtask

  initial begin
    bit err;
    int m, e, n1;
    seq_if.start   = 1'b0;
    seq_if.abort   = 1'b0;
    seq_if.modo    = 2'd0;
    seq_if.done_in = '0;

    // Reset state
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b0;

    // abort together with start in IDLE keeps the block idle
    seq_if.start = 1'b1;
    seq_if.abort = 1'b1;
    @(negedge clock);
    seq_if.start = 1'b0;
    seq_if.abort = 1'b0;
    chk("abort_start.ocupado", 32'(seq_if.ocupado), 0);
    @(negedge clock);
    chk("abort_start.ocupado2", 32'(seq_if.ocupado), 0);

    // Nominal: done on ch1's 5th on-cycle
    run_seq("nominal", 1, 5, 1'b0, 1'b0, 0, err);
    // ch1 never reports done: timeout held on ch1, then restart from ERROR
    run_seq("timeout", 1, 0, 1'b0, 1'b0, 0, err);
    chk("timeout.err_expected", 32'(err), 1);
    run_seq("restart", 1, 8, 1'b0, 1'b0, 0, err);
    // ch0 skipped
    run_seq("skip", 2, 3, 1'b0, 1'b0, 0, err);
    // abort mid ch2, then a fresh full run
    run_seq("abort", 1, 2, 1'b0, 1'b0, 1, err);
    run_seq("after_abort", 0, 1, 1'b0, 1'b0, 0, err);
    // start pulses / modo toggles while busy, done on ch0/ch2 held high
    run_seq("perturb", 1, 4, 1'b1, 1'b1, 0, err);
    // reset in the middle of a gap
    run_seq("reset_gap", 0, 2, 1'b0, 1'b0, 2, err);

    // Randomized recipes and feedback timing
    for (int it = 0; it < 16; it++) begin
      m  = $urandom_range(0, 3);
      n1 = dur[1][m] * B;
      e  = $urandom_range(0, n1 + 1);
      run_seq($sformatf("rand%0d", it), m, e, 1'($urandom), 1'($urandom), 0, err);
      if (err && $urandom_range(0, 1) == 1) begin
        seq_if.abort = 1'b1;
        @(negedge clock);
        seq_if.abort = 1'b0;
        chk($sformatf("rand%0d.abort_err.timeout", it), 32'(seq_if.timeout), 0);
        chk($sformatf("rand%0d.abort_err.ocupado", it), 32'(seq_if.ocupado), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
